// File: rtl/gpu_circle_raster.sv
// gpu_circle_raster
//
// Midpoint-circle rasteriser for the GPU draw path. A job walks the first
// octant of the circle (tx from 0 up to the diagonal). Each step visits up to
// eight mirrored octant positions and emits each visible one as a pixel on a
// valid/ready stream. An 8-bit mask selects which octants take part.
// Off-screen positions are clipped. Points that two octants share on the axes
// or on the diagonal are emitted only once, by the lower-indexed octant.
//
// Ports
//   clk        in   clock
//   n_rst      in   asynchronous active-low reset
//   start      in   one-cycle job request, honoured only when idle
//   abort      in   cancels the current job; no done pulse follows
//   xc, yc     in   circle centre, latched at start
//   rad        in   radius, latched at start
//   oct_mask   in   octant enable mask (bit k = octant k), latched at start
//   busy       out  job in progress
//   done       out  one-cycle pulse when a job completes normally
//   pix_valid  out  pix_x/pix_y carry a visible pixel
//   pix_ready  in   consumer takes the pixel when pix_valid && pix_ready
//   pix_x      out  pixel x
//   pix_y      out  pixel y

module gpu_circle_raster #(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH_BITS-1:0]  xc,
  input  logic [HEIGHT_BITS-1:0] yc,
  input  logic [WIDTH_BITS-1:0]  rad,
  input  logic [7:0]             oct_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [WIDTH_BITS-1:0]  pix_x,
  output logic [HEIGHT_BITS-1:0] pix_y
);

  // Signed widths. Coordinates get two extra bits so that the centre plus or
  // minus the radius never wraps. The decision variable gets one more bit
  // for the 2(tx-ty)+5 update.
  localparam int CW = WIDTH_BITS + 2;
  localparam int FW = WIDTH_BITS + 3;

  localparam logic signed [CW-1:0] SCR_W = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SCR_H = CW'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic signed [CW-1:0]     tx_q, tx_d;
  logic signed [CW-1:0]     ty_q, ty_d;
  logic signed [FW-1:0]     f_q, f_d;
  logic [2:0]               oct_idx_q, oct_idx_d;
  logic [WIDTH_BITS-1:0]    xc_q, xc_d;
  logic [HEIGHT_BITS-1:0]   yc_q, yc_d;
  logic [WIDTH_BITS-1:0]    rad_q, rad_d;
  logic [7:0]               mask_q, mask_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pix_valid_q, pix_valid_d;
  logic [WIDTH_BITS-1:0]    pix_x_q, pix_x_d;
  logic [HEIGHT_BITS-1:0]   pix_y_q, pix_y_d;

  // Midpoint step candidates, computed from the current position.
  logic signed [FW-1:0]     tx_ext, ty_ext;
  logic signed [FW-1:0]     f_step;
  logic signed [CW-1:0]     tx_step, ty_step;

  // Octant evaluation of the next-state position.
  logic signed [CW-1:0]     xc_s, yc_s;
  logic signed [CW-1:0]     cx, cy;
  logic [2:0]               partner_axis, partner_diag;
  logic [7:0]               lower_mask;
  logic                     on_screen, skip_axis, skip_diag, skip_zero, emit;

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      ty_q        <= '0;
      f_q         <= '0;
      oct_idx_q   <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      rad_q       <= '0;
      mask_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      f_q         <= f_d;
      oct_idx_q   <= oct_idx_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      rad_q       <= rad_d;
      mask_q      <= mask_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
    end
  end

  // One midpoint iteration. A negative F keeps ty. Otherwise ty moves one
  // row towards the axis.
  always_comb begin
    tx_ext  = {tx_q[CW-1], tx_q};
    ty_ext  = {ty_q[CW-1], ty_q};
    tx_step = tx_q + CW'(1);
    if (f_q[FW-1]) begin
      f_step  = f_q + (tx_ext <<< 1) + FW'(3);
      ty_step = ty_q;
    end else begin
      f_step  = f_q + ((tx_ext - ty_ext) <<< 1) + FW'(5);
      ty_step = ty_q - CW'(1);
    end
  end

  // Next-state logic. A pending pixel that is not accepted freezes the scan.
  // abort wins over everything else.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    f_d       = f_q;
    oct_idx_d = oct_idx_q;
    xc_d      = xc_q;
    yc_d      = yc_q;
    rad_d     = rad_q;
    mask_d    = mask_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          xc_d      = xc;
          yc_d      = yc;
          rad_d     = rad;
          mask_d    = oct_mask;
          tx_d      = '0;
          ty_d      = $signed({2'b00, rad});
          f_d       = FW'(1) - $signed({3'b000, rad});
          oct_idx_d = '0;
        end
      end
      SCAN: begin
        if (!(pix_valid_q && !pix_ready)) begin
          if (oct_idx_q == 3'd7) begin
            state_d = STEP;
          end else begin
            oct_idx_d = oct_idx_q + 3'd1;
          end
        end
      end
      STEP: begin
        f_d       = f_step;
        tx_d      = tx_step;
        ty_d      = ty_step;
        oct_idx_d = '0;
        state_d   = (tx_step > ty_step) ? DONE : SCAN;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
    end
  end

  // The pixel is evaluated from the next-state values and then registered.
  // This keeps pix_valid aligned with the octant index currently held, and it
  // makes the octant-0 pixel available in the first cycle after start.
  always_comb begin
    xc_s = $signed({2'b00, xc_d});
    yc_s = $signed({{(CW-HEIGHT_BITS){1'b0}}, yc_d});

    case (oct_idx_d)
      3'd0:    begin cx = xc_s + ty_d; cy = yc_s + tx_d; end
      3'd1:    begin cx = xc_s + tx_d; cy = yc_s + ty_d; end
      3'd2:    begin cx = xc_s - tx_d; cy = yc_s + ty_d; end
      3'd3:    begin cx = xc_s - ty_d; cy = yc_s + tx_d; end
      3'd4:    begin cx = xc_s - ty_d; cy = yc_s - tx_d; end
      3'd5:    begin cx = xc_s - tx_d; cy = yc_s - ty_d; end
      3'd6:    begin cx = xc_s + tx_d; cy = yc_s - ty_d; end
      default: begin cx = xc_s + ty_d; cy = yc_s - tx_d; end
    endcase

    on_screen = !cx[CW-1] && !cy[CW-1] && (cx < SCR_W) && (cy < SCR_H);

    // Octants that meet on an axis pair up as 7-0, 1-2, 3-4, 5-6. Octants
    // that meet on a diagonal pair up as 0-1, 2-3, 4-5, 6-7.
    partner_axis = oct_idx_d[0] ? (oct_idx_d + 3'd1) : (oct_idx_d - 3'd1);
    partner_diag = oct_idx_d ^ 3'd1;

    skip_axis = (tx_d == '0) && mask_d[partner_axis] && (partner_axis < oct_idx_d);
    skip_diag = (tx_d == ty_d) && mask_d[partner_diag] && (partner_diag < oct_idx_d);

    // A zero radius puts all eight octants on the centre point. Only the
    // lowest enabled octant emits it.
    lower_mask = (8'd1 << oct_idx_d) - 8'd1;
    skip_zero  = (rad_d == '0) && ((mask_d & lower_mask) != 8'd0);

    emit = mask_d[oct_idx_d] && on_screen && !skip_axis && !skip_diag && !skip_zero;

    pix_valid_d = (state_d == SCAN) && emit;
    pix_x_d     = pix_valid_d ? cx[WIDTH_BITS-1:0]  : pix_x_q;
    pix_y_d     = pix_valid_d ? cy[HEIGHT_BITS-1:0] : pix_y_q;
    busy_d      = (state_d == SCAN) || (state_d == STEP);
    done_d      = (state_d == DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;

endmodule
